iter_muldiv: RTL and testbench

- Parametrised successor to the iterative 32-bit multiplier.
- Sequential multiply/divide unit: WIDTH-bit operands, 2*WIDTH-bit result, signed or unsigned, one bit per cycle.
- Sits beside the ALU in the processor datapath. `stall` holds the pipeline while the unit is busy.

---
 rtl/iter_muldiv_if.sv | 23 ++
 rtl/iter_muldiv.sv | 150 +++++++++++++++
 tb/tb_iter_muldiv.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// iter_muldiv_if: request/response bundle between the datapath and the
// iterative multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   result;
  logic                 out_valid;
  logic                 stall;

  modport master (
    output in_valid, mode, op_a, op_b,
    input  result, out_valid, stall
  );

  modport slave (
    input  in_valid, mode, op_a, op_b,
    output result, out_valid, stall
  );
endinterface

// File: rtl/iter_muldiv.sv
// iter_muldiv: sequential multiply/divide unit, one result bit per cycle.
// Modes: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
// Multiply result is the full product; divide result is {remainder, quotient}.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- multiplies finish as soon as
// the remaining multiplier magnitude bits are all zero.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  iter_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic                 is_div;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     a_raw;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand_sh;
  logic [2*WIDTH-1:0]   result_q;
  logic                 out_valid_q;
  logic [CW-1:0]        cnt;

  logic                 calc_last;
  logic [WIDTH-1:0]     mag_a_in;
  logic [WIDTH-1:0]     mag_b_in;
  logic [WIDTH:0]       trial;
  logic                 trial_ge;
  logic [WIDTH-1:0]     trial_sub;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
  logic [2*WIDTH-1:0]   final_result;

  assign bus.stall     = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

`ifdef MULDIV_EARLY_OUT_EN
  // A multiply is complete once every remaining multiplier bit has been consumed.
  assign calc_last = (cnt == CW'(WIDTH)) || (!is_div && (cnt != '0) && (work == '0));
`else
  assign calc_last = (cnt == CW'(WIDTH));
`endif

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a_in = bus.op_a;
    mag_b_in = bus.op_b;
    if (bus.mode[0] && bus.op_a[WIDTH-1]) mag_a_in = -bus.op_a;
    if (bus.mode[0] && bus.op_b[WIDTH-1]) mag_b_in = -bus.op_b;
  end

  // Restoring-division trial subtract for the next quotient bit.
  always_comb begin
    trial     = {rem, work[WIDTH-1]};
    trial_ge  = (trial >= {1'b0, mag_b});
    trial_sub = trial[WIDTH-1:0] - mag_b;
  end

  // Sign correction and divide-by-zero handling for the final result.
  always_comb begin
    q_fix        = work;
    r_fix        = rem;
    final_result = acc;
    if (!is_div) begin
      if (sign_a ^ sign_b) final_result = -acc;
    end else if (mag_b == '0) begin
      final_result = {a_raw, {WIDTH{1'b1}}};
    end else begin
      if (sign_a ^ sign_b) q_fix = -work;
      if (sign_a)          r_fix = -rem;
      final_result = {r_fix, q_fix};
    end
  end

  // Control FSM and iteration datapath: accept, iterate, publish, return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_raw       <= '0;
      mag_b       <= '0;
      work        <= '0;
      rem         <= '0;
      acc         <= '0;
      mcand_sh    <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (bus.in_valid) begin
            is_div   <= bus.mode[1];
            sign_a   <= bus.mode[0] & bus.op_a[WIDTH-1];
            sign_b   <= bus.mode[0] & bus.op_b[WIDTH-1];
            a_raw    <= bus.op_a;
            mag_b    <= mag_b_in;
            work     <= mag_a_in;
            mcand_sh <= {{WIDTH{1'b0}}, mag_b_in};
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (calc_last) begin
            result_q    <= final_result;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (!is_div) begin
              if (work[0]) acc <= acc + mcand_sh;
              mcand_sh <= mcand_sh << 1;
              work     <= work >> 1;
            end else if (trial_ge) begin
              rem  <= trial_sub;
              work <= {work[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= trial[WIDTH-1:0];
              work <= {work[WIDTH-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: scoreboard bench for iter_muldiv (WIDTH=32).
// Expected results come from plain-arithmetic reference functions; a monitor
// pops the scoreboard whenever the unit raises out_valid.
module tb_iter_muldiv;

  localparam int W = 32;

  typedef struct {
    logic [63:0] res;
    int          acc_cyc;
    int          lat;
    int          id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   next_id;
  logic [63:0] held_result;
  exp_t sb_q[$];

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference arithmetic written straight from the mode definitions.
  function automatic logic [63:0] refModel(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (m)
      2'b00: res = ua * ub;
      2'b01: res = 64'(sa * sb);
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Cycles from the accept edge to out_valid.
  function automatic int expLatency(input logic [1:0] m, input logic [31:0] a);
    int n;
    n = W;
`ifdef MULDIV_EARLY_OUT_EN
    if (!m[1]) begin
      logic [31:0] mag;
      mag = (m[0] && a[31]) ? -a : a;
      n = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    end
`endif
    return n + 1;
  endfunction

  task automatic pushExpected(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res     = refModel(m, a, b);
    e.acc_cyc = cyc;
    e.lat     = expLatency(m, a);
    e.id      = next_id;
    next_id++;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for a negedge where the unit is idle.
  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("wait_idle_timeout", 64'(bus.stall), 64'd0);
  endtask

  // Issue one request once the unit is idle; returns right after the accept edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    waitIdle(ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.mode     = m;
      bus.op_a     = a;
      bus.op_b     = b;
      @(posedge clk);
      #1;
      pushExpected(m, a, b);
      bus.in_valid = 1'b0;
      checkOutput("stall_after_accept", 64'(bus.stall), 64'd1);
      checkOutput("result_held_on_accept", bus.result, held_result);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput($sformatf("result_op%0d", e.id), bus.result, e.res);
        checkOutput($sformatf("latency_op%0d", e.id), 64'(cyc - e.acc_cyc), 64'(e.lat));
        checkOutput($sformatf("stall_at_done_op%0d", e.id), 64'(bus.stall), 64'd1);
        held_result = e.res;
      end
    end
  end

  initial begin
    bit ok;
    int stall_cnt;
    bit changed;
    int next_idx;
    logic [1:0] m;
    logic [31:0] a, b;

    cyc = 0; n_tests = 0; n_fail = 0; next_id = 0;
    held_result = 64'd0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.op_a = '0;
    bus.op_b = '0;

    #3;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall), 64'd0);
    checkOutput("reset_result", bus.result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned multiply with stall-width and result-hold tracking.
    applyStimulus(2'b00, 32'd5, 32'd6);
    stall_cnt = 0;
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stall_cnt++;
      if (!bus.out_valid && bus.result !== held_result) changed = 1'b1;
    end
    checkOutput("stall_width", 64'(stall_cnt), 64'(expLatency(2'b00, 32'd5) + 1));
    checkOutput("result_stable_in_calc", 64'(changed), 64'd0);

    // Directed cases.
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7);
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000);
    applyStimulus(2'b00, 32'd0, 32'd12345);
    applyStimulus(2'b10, 32'd100, 32'd7);
    applyStimulus(2'b11, 32'hFFFF_FF9C, 32'd7);
    applyStimulus(2'b11, 32'd100, 32'hFFFF_FFF9);
    applyStimulus(2'b10, 32'd123, 32'd0);
    applyStimulus(2'b11, 32'hFFFF_FF85, 32'd0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);

    // in_valid held high with changing operands: only idle edges accept.
    next_idx = expLatency(2'b10, 32'd0) + 2;
    waitIdle(ok);
    if (ok) begin
      for (int j = 0; j <= next_idx; j++) begin
        if (j != 0) @(negedge clk);
        m = {1'b1, 1'($urandom_range(0, 1))};
        a = $urandom;
        b = $urandom | 32'd1;
        bus.in_valid = 1'b1;
        bus.mode = m;
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk);
        #1;
        if (j == 0 || j == next_idx) pushExpected(m, a, b);
      end
      bus.in_valid = 1'b0;
    end

    // Reset in the middle of a divide.
    applyStimulus(2'b10, 32'd100, 32'd7);
    applyStimulus(2'b10, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset_stall", 64'(bus.stall), 64'd0);
    checkOutput("midreset_result", bus.result, 64'd0);
    sb_q.delete();
    held_result = 64'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 32'd6, 32'd7);

    // Randomised mix with boundary operands sprinkled in.
    for (int k = 0; k < 40; k++) begin
      m = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: a = 32'($urandom_range(0, 40));
        4: b = 32'($urandom_range(1, 40));
        default: ;
      endcase
      applyStimulus(m, a, b);
    end

    // Drain the scoreboard.
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
